// File: rtl/output_port_bank_if.sv
// Bus bundle between the CPU/consumer side and the output port bank.
// The master side drives writes, pops and overflow clears; the bank
// (slave side) returns per-port head data and status flags.
interface output_port_bank_if #(
  parameter int WIDTH  = 8,
  parameter int NPORTS = 4,
  parameter int SELW   = 2
);
  logic                     we;
  logic [SELW-1:0]          sel_port;
  logic [WIDTH-1:0]         in_RD2;
  logic [NPORTS*WIDTH-1:0]  out_data;
  logic [NPORTS-1:0]        out_valid;
  logic [NPORTS-1:0]        ack;
  logic [NPORTS-1:0]        full;
  logic [NPORTS-1:0]        overflow;
  logic [NPORTS-1:0]        clr_ovf;
  logic                     sel_full;

  modport master (
    output we, sel_port, in_RD2, ack, clr_ovf,
    input  out_data, out_valid, full, overflow, sel_full
  );

  modport slave (
    input  we, sel_port, in_RD2, ack, clr_ovf,
    output out_data, out_valid, full, overflow, sel_full
  );
endinterface

// File: rtl/output_port_bank.sv
// CPU output-port bank: NPORTS independent channels, each a DEPTH-entry
// FIFO written by the CPU output instruction and drained by an external
// consumer through a valid/ack handshake. Single clock, no gated clocks;
// every output is a decode of registered state (plus sel_port).
module output_port_bank #(
  parameter int WIDTH  = 8,
  parameter int NPORTS = 4,
  parameter int SELW   = 2,
  parameter int DEPTH  = 2
) (
  input  logic                clk,
  input  logic                reset,
  output_port_bank_if.slave   bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef logic [WIDTH-1:0] word_t;

  word_t             mem_q    [NPORTS][DEPTH];
  word_t             mem_d    [NPORTS][DEPTH];
  logic [PW-1:0]     rd_ptr_q [NPORTS];
  logic [PW-1:0]     rd_ptr_d [NPORTS];
  logic [PW-1:0]     wr_ptr_q [NPORTS];
  logic [PW-1:0]     wr_ptr_d [NPORTS];
  logic [CW-1:0]     count_q  [NPORTS];
  logic [CW-1:0]     count_d  [NPORTS];
  logic [NPORTS-1:0] overflow_q;
  logic [NPORTS-1:0] overflow_d;

  logic [NPORTS-1:0] wr_hit;
  logic [NPORTS-1:0] pop;
  logic [NPORTS-1:0] accept;

  // Per-port write/pop decode; a full port still accepts when it pops in the same cycle
  always_comb begin
    wr_hit = '0;
    pop    = '0;
    accept = '0;
    for (int p = 0; p < NPORTS; p++) begin
      wr_hit[p] = bus.we && (bus.sel_port == SELW'(p));
      pop[p]    = bus.ack[p] && (count_q[p] != '0);
      accept[p] = wr_hit[p] && ((count_q[p] != CW'(DEPTH)) || pop[p]);
    end
  end

  // Next-state for storage, pointers, occupancy and sticky overflow
  always_comb begin
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    for (int p = 0; p < NPORTS; p++) begin
      if (accept[p]) begin
        mem_d[p][wr_ptr_q[p]] = bus.in_RD2;
        wr_ptr_d[p]           = wr_ptr_q[p] + PW'(1);
      end
      if (pop[p]) begin
        rd_ptr_d[p] = rd_ptr_q[p] + PW'(1);
      end
      if (accept[p] && !pop[p]) begin
        count_d[p] = count_q[p] + CW'(1);
      end else if (pop[p] && !accept[p]) begin
        count_d[p] = count_q[p] - CW'(1);
      end
      if (wr_hit[p] && !accept[p]) begin
        overflow_d[p] = 1'b1;
      end else if (bus.clr_ovf[p]) begin
        overflow_d[p] = 1'b0;
      end
    end
  end

  // State registers; reset clears everything immediately, including storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NPORTS; p++) begin
        for (int e = 0; e < DEPTH; e++) begin
          mem_q[p][e] <= '0;
        end
        rd_ptr_q[p] <= '0;
        wr_ptr_q[p] <= '0;
        count_q[p]  <= '0;
      end
      overflow_q <= '0;
    end else begin
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Status and head-data decode from registered state; head reads as 0 when empty
  always_comb begin
    bus.out_data  = '0;
    bus.out_valid = '0;
    bus.full      = '0;
    bus.sel_full  = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      if (count_q[p] != '0) begin
        bus.out_valid[p]                 = 1'b1;
        bus.out_data[p*WIDTH +: WIDTH]   = mem_q[p][rd_ptr_q[p]];
      end
      bus.full[p] = (count_q[p] == CW'(DEPTH));
      if (bus.sel_port == SELW'(p)) begin
        bus.sel_full = (count_q[p] == CW'(DEPTH));
      end
    end
  end

  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_output_port_bank.sv
// Self-checking bench for output_port_bank: directed vectors with
// hand-computed values, plus a per-port queue model checked every cycle.
module tb_output_port_bank;

  localparam int WIDTH  = 8;
  localparam int NPORTS = 4;
  localparam int SELW   = 2;
  localparam int DEPTH  = 2;

  logic clk = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq [NPORTS][$];
  bit         movf [NPORTS];

  always #5 clk = ~clk;

  output_port_bank_if #(.WIDTH(WIDTH), .NPORTS(NPORTS), .SELW(SELW)) bus ();
  output_port_bank_if #(.WIDTH(WIDTH), .NPORTS(3), .SELW(SELW)) bus3 ();

  output_port_bank #(.WIDTH(WIDTH), .NPORTS(NPORTS), .SELW(SELW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  output_port_bank #(.WIDTH(WIDTH), .NPORTS(3), .SELW(SELW), .DEPTH(DEPTH)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Compare every port against the queue model
  task automatic checkAllPorts(input string tag);
    int sz;
    logic [7:0] exp_data;
    for (int p = 0; p < NPORTS; p++) begin
      sz = mq[p].size();
      exp_data = (sz > 0) ? mq[p][0] : 8'h00;
      checkOutput($sformatf("%s valid%0d", tag, p), 32'(bus.out_valid[p]), 32'(sz > 0));
      checkOutput($sformatf("%s data%0d", tag, p), 32'(bus.out_data[p*WIDTH +: WIDTH]), 32'(exp_data));
      checkOutput($sformatf("%s full%0d", tag, p), 32'(bus.full[p]), 32'(sz == DEPTH));
      checkOutput($sformatf("%s ovf%0d", tag, p), 32'(bus.overflow[p]), 32'(movf[p]));
    end
    checkOutput($sformatf("%s sel_full", tag), 32'(bus.sel_full),
                32'(mq[int'(bus.sel_port)].size() == DEPTH));
  endtask

  // Drive one cycle of inputs, advance the model for that edge, then check after it
  task automatic applyStimulus(input bit w, input logic [1:0] s, input logic [7:0] d,
                               input logic [3:0] a, input logic [3:0] c);
    bit pop_m, hit_m, acc_m;
    bus.we       = w;
    bus.sel_port = s;
    bus.in_RD2   = d;
    bus.ack      = a;
    bus.clr_ovf  = c;
    for (int p = 0; p < NPORTS; p++) begin
      pop_m = a[p] && (mq[p].size() > 0);
      hit_m = w && (int'(s) == p);
      acc_m = hit_m && ((mq[p].size() < DEPTH) || pop_m);
      if (pop_m) void'(mq[p].pop_front());
      if (acc_m) mq[p].push_back(d);
      if (hit_m && !acc_m) movf[p] = 1'b1;
      else if (c[p]) movf[p] = 1'b0;
    end
    @(posedge clk);
    #1;
    checkAllPorts("cyc");
  endtask

  initial begin
    reset         = 1'b1;
    bus.we        = 1'b0;
    bus.sel_port  = '0;
    bus.in_RD2    = '0;
    bus.ack       = '0;
    bus.clr_ovf   = '0;
    bus3.we       = 1'b0;
    bus3.sel_port = '0;
    bus3.in_RD2   = '0;
    bus3.ack      = '0;
    bus3.clr_ovf  = '0;
    for (int p = 0; p < NPORTS; p++) movf[p] = 1'b0;

    #12;
    checkOutput("rst out_data", bus.out_data, 32'h0);
    checkOutput("rst out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("rst full", 32'(bus.full), 32'h0);
    checkOutput("rst overflow", 32'(bus.overflow), 32'h0);
    checkOutput("rst sel_full", 32'(bus.sel_full), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(0, 0, 8'h00, 4'h0, 4'h0);
    checkOutput("idle out_data", bus.out_data, 32'h0);

    // Single write to port 2 then pop
    applyStimulus(1, 2, 8'hA5, 4'h0, 4'h0);
    checkOutput("a5 out_data", bus.out_data, 32'h00A5_0000);
    checkOutput("a5 out_valid", 32'(bus.out_valid), 32'h4);
    applyStimulus(0, 2, 8'h00, 4'b0100, 4'h0);
    checkOutput("a5 pop valid", 32'(bus.out_valid), 32'h0);
    checkOutput("a5 pop data", bus.out_data, 32'h0);

    // Fill port 0, overflow on the third write, drain, clear
    applyStimulus(1, 0, 8'h11, 4'h0, 4'h0);
    checkOutput("p0 full after 1", 32'(bus.full), 32'h0);
    applyStimulus(1, 0, 8'h22, 4'h0, 4'h0);
    checkOutput("p0 full after 2", 32'(bus.full), 32'h1);
    checkOutput("p0 sel_full", 32'(bus.sel_full), 32'h1);
    applyStimulus(1, 0, 8'h33, 4'h0, 4'h0);
    checkOutput("p0 overflow", 32'(bus.overflow), 32'h1);
    checkOutput("p0 head 11", 32'(bus.out_data[7:0]), 32'h11);
    applyStimulus(0, 0, 8'h00, 4'b0001, 4'h0);
    checkOutput("p0 head 22", 32'(bus.out_data[7:0]), 32'h22);
    applyStimulus(0, 0, 8'h00, 4'b0001, 4'h0);
    checkOutput("p0 drained", 32'(bus.out_valid), 32'h0);
    checkOutput("p0 ovf sticky", 32'(bus.overflow), 32'h1);
    applyStimulus(0, 0, 8'h00, 4'h0, 4'b0001);
    checkOutput("p0 ovf cleared", 32'(bus.overflow), 32'h0);

    // Port 3 full, write with simultaneous pop is accepted
    applyStimulus(1, 3, 8'h77, 4'h0, 4'h0);
    applyStimulus(1, 3, 8'h88, 4'h0, 4'h0);
    applyStimulus(1, 3, 8'h44, 4'b1000, 4'h0);
    checkOutput("p3 full kept", 32'(bus.full), 32'h8);
    checkOutput("p3 head 88", 32'(bus.out_data[31:24]), 32'h88);
    checkOutput("p3 no ovf", 32'(bus.overflow), 32'h0);
    applyStimulus(0, 3, 8'h00, 4'b1000, 4'h0);
    checkOutput("p3 head 44", 32'(bus.out_data[31:24]), 32'h44);
    applyStimulus(0, 3, 8'h00, 4'b1000, 4'h0);
    checkOutput("p3 drained", 32'(bus.out_valid), 32'h0);

    // Empty port 1: write plus ack in the same cycle leaves one entry
    applyStimulus(1, 1, 8'h5A, 4'b0010, 4'h0);
    checkOutput("p1 wr+ack data", bus.out_data, 32'h0000_5A00);
    checkOutput("p1 wr+ack full", 32'(bus.full), 32'h0);
    applyStimulus(0, 1, 8'h00, 4'b0010, 4'h0);

    // Three-port instance: sel_port 3 is out of range and ignored
    bus3.we = 1'b1; bus3.sel_port = 2'd3; bus3.in_RD2 = 8'hFF;
    @(posedge clk);
    #1;
    checkOutput("np3 sel3 valid", 32'(bus3.out_valid), 32'h0);
    checkOutput("np3 sel3 data", 32'(bus3.out_data), 32'h0);
    checkOutput("np3 sel3 ovf", 32'(bus3.overflow), 32'h0);
    checkOutput("np3 sel3 sel_full", 32'(bus3.sel_full), 32'h0);
    bus3.sel_port = 2'd2; bus3.in_RD2 = 8'h3C;
    @(posedge clk);
    #1;
    bus3.we = 1'b0;
    checkOutput("np3 sel2 valid", 32'(bus3.out_valid), 32'h4);
    checkOutput("np3 sel2 data", 32'(bus3.out_data), 32'h3C_0000);

    // Asynchronous reset mid-run with port 1 holding two entries
    applyStimulus(1, 1, 8'h61, 4'h0, 4'h0);
    applyStimulus(1, 1, 8'h62, 4'h0, 4'h0);
    checkOutput("p1 pre-rst full", 32'(bus.full), 32'h2);
    bus.we = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async rst valid", 32'(bus.out_valid), 32'h0);
    checkOutput("async rst data", bus.out_data, 32'h0);
    checkOutput("async rst full", 32'(bus.full), 32'h0);
    checkOutput("async rst np3 valid", 32'(bus3.out_valid), 32'h0);
    for (int p = 0; p < NPORTS; p++) begin
      mq[p].delete();
      movf[p] = 1'b0;
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1, 1, 8'h63, 4'h0, 4'h0);
    checkOutput("post-rst p1 data", bus.out_data, 32'h0000_6300);
    checkOutput("post-rst p1 full", 32'(bus.full), 32'h0);

    // Random interleaving against the queue model
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom),
                    4'($urandom & $urandom),
                    ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_port_bank.md
# output_port_bank

Parametrised CPU output-port bank: NPORTS independent output channels, each WIDTH bits wide and backed by a DEPTH-entry FIFO, written by the CPU's output instruction from register-file read port 2. Each channel exposes a valid/ack handshake to the external consumer and status flags, so back-to-back CPU writes are buffered rather than overwritten. It replaces the fixed 4×8-bit latch bank with a fully synchronous, single-clock design with no gated clocks.

## Interface
- WIDTH, 8, data width per port
- NPORTS, 4, number of output ports (≥2)
- SELW, 2, width of sel_port; 2^SELW ≥ NPORTS
- DEPTH, 2, FIFO entries per port; power of two, ≥2

- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- we  in  1  CPU output-write strobe, one write per cycle high
- sel_port  in  SELW  target port index
- in_RD2  in  WIDTH  write data (register-file read port 2)
- out_data  out  NPORTS*WIDTH  port p head data at bits [p*WIDTH +: WIDTH]
- out_valid  out  NPORTS  port p holds ≥1 entry
- ack  in  NPORTS  consumer pop request per port
- full  out  NPORTS  port p holds DEPTH entries
- overflow  out  NPORTS  sticky: a write to port p was dropped
- clr_ovf  in  NPORTS  clears overflow[p]
- sel_full  out  1  full[sel_port] (0 if sel_port ≥ NPORTS); CPU stall hint

## Operation
- Per port: storage DEPTH×WIDTH, rd_ptr/wr_ptr of log2(DEPTH) bits wrapping modulo DEPTH, count of log2(DEPTH)+1 bits (0..DEPTH).
- Write: we=1 and sel_port=p<NPORTS. Accepted if count<DEPTH, or count==DEPTH with pop on p in the same cycle. Accepted: mem[wr_ptr]←in_RD2, wr_ptr++. Rejected (full, no pop): data dropped, overflow[p]←1, no other state change.
- sel_port ≥ NPORTS: write ignored entirely; no flag changes.
- Pop: ack[p]=1 and count>0 → rd_ptr++. ack on an empty port is ignored.
- Count: +1 on accepted write only, −1 on pop only, unchanged on both or neither.
- Write and pop on an empty port in the same cycle: write accepted, pop ignored, count→1.
- out_data slice p = mem[rd_ptr] when count>0, else 0. out_valid[p]=(count>0). full[p]=(count==DEPTH).
- overflow[p]: set on a dropped write, cleared by clr_ovf[p]. Set and clear in the same cycle → set wins.
- Ports are fully independent; ack/clr_ovf on one port never affects another.

## Timing
- Reset (asynchronous, any time, including mid-burst): all counts 0, all pointers 0, storage 0, out_valid=0, full=0, overflow=0, out_data=0, sel_full=0. Takes effect immediately, not at the next edge.
- Write latency: data written at edge N appears on out_data, with out_valid=1, after edge N when the port was empty. Otherwise it appears after the pop that makes it head.
- Pop: head advances at the edge where ack=1 and valid=1. The new head, or 0 with valid=0, is visible after that edge.
- Consumer rule: sample out_data in any cycle where out_valid=1. Holding ack high drains one entry per cycle.
- full, overflow, sel_full: registered state or a combinational decode of registered state plus sel_port; no combinational path from we/in_RD2/ack to any output.
- Sustained throughput: one write and one pop per port per cycle.

## Test plan
- Reset, then idle: all outputs 0. Assert reset mid-run with port 1 holding 2 entries → out_valid[1]=0, out_data=0, count 0 with no clock edge required.
- Write 0xA5 to port 2 at edge N → out_valid[2]=1 and slice 2=0xA5 after N. Other ports stay valid=0 and data 0. ack[2] for one cycle → valid[2]=0, data 0.
- DEPTH=2: write 0x11, 0x22, 0x33 to port 0 with no ack → full[0]=1 after the 2nd write, sel_full=1 while sel_port=0, overflow[0]=1 after the 3rd write. Drain → 0x11 then 0x22; 0x33 is never seen. clr_ovf[0] → overflow[0]=0.
- Port 3 full, write 0x44 with ack[3] in the same cycle → write accepted, full stays 1, drained order is old entry 2 then 0x44, overflow[3]=0.
- Empty port 1, write 0x5A with ack[1] the same cycle → count 1, out_data 0x5A. With NPORTS=3, SELW=2, write to sel_port=3 → no state change anywhere.
- Random interleaving of writes, acks, and clr_ovf on all ports against a per-port queue model → data order, valid, full, and overflow match every cycle.
